tick_gen: RTL and testbench
===========================

# tick_gen

Enable-tick generator sitting directly upstream of the 4-bit up-counter: it drives the counter's `en` input. A programmable prescaler turns the system clock into one-cycle `en` pulses every `div` clocks under a start/pause/stop/single-step control FSM, so the counter advances at a controlled rate instead of every clock.

## Interface
- `DIV_W`, 8: width of the divisor and prescaler.
- `DEFAULT_DIV`, 10: divisor value loaded at reset.
- `BURST_W`, 4: width of the burst length; used only with `TICK_GEN_BURST_EN`.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level-sampled; IDLE→RUN, or PAUSE→RUN (resume).
- `pause`  in  1  RUN→PAUSE; prescaler frozen.
- `stop`  in  1  any state→IDLE; prescaler cleared.
- `step`  in  1  in IDLE/PAUSE: emit exactly one `en` pulse.
- `load_div`  in  1  write strobe for `div_in`.
- `div_in`  in  DIV_W  new divisor; 0 is treated as 1.
- `en`  out  1  registered tick to the counter, one cycle wide.
- `running`  out  1  state == RUN.
- `paused`  out  1  state == PAUSE.
- `burst_len`  in  BURST_W  ticks per run; 0 = free-run (macro only).
- `done`  out  1  one-cycle pulse on burst completion (macro only).

## Operation
- FSM states: IDLE, RUN, PAUSE.
- Command priority when several are high on one edge: stop > start > pause > step.
- IDLE: `pre` held at 0. `start` → RUN. `step` → `en`=1 for the next cycle; state unchanged.
- RUN: `pre` increments each edge. At the edge where `pre == div_q-1`, `en`←1 and `pre`←0. Otherwise `en`←0.
  - `pause` → PAUSE with `pre` frozen and `en`←0.
  - `stop` → IDLE with `pre`←0 and `en`←0, even on a wrap edge.
- PAUSE: `start` resumes RUN from the frozen `pre`. `step` emits one `en` pulse with `pre` unchanged. `stop` → IDLE.
- `step` in RUN is ignored.
- Divisor loading:
  - Outside RUN: `load_div` writes `div_q` directly.
  - In RUN: the value goes to shadow register `div_sh` and is copied into `div_q` at the next wrap edge.
  - `load_div` coinciding with a wrap edge: the new value is used for the following period.
- `div_q == 1`: `en` is high on every cycle while in RUN.

## Timing
- Reset values: state IDLE, `pre`=0, `div_q`=`div_sh`=`DEFAULT_DIV`, `en`=0, `running`=0, `paused`=0, `done`=0.
- The first `en` appears `div_q` cycles after the edge that samples `start` in IDLE. Example: `div`=4, start at edge 0 → `en` high after edge 4.
- After that, `en` repeats every `div_q` cycles and is never wider than one cycle.
- Step latency is 1 cycle. A held `step` pulses once per cycle.
- Resume from PAUSE: the next `en` comes after the remaining (`div_q-1-pre`) + 1 cycles.
- Asserting `rst` mid-period forces all reset values immediately, with no `en` glitch. Operation restarts in IDLE.
- `running` and `paused` are decoded from the registered state and are valid the cycle after the transition edge.

## Configuration
- `TICK_GEN_BURST_EN` defined:
  - `burst_len` and `done` ports exist.
  - On entry to RUN from IDLE, a burst counter loads `burst_len`.
  - Each RUN `en` decrements the counter. On the edge that produces the final tick, state←IDLE and `done`←1 for one cycle, coincident with that `en`.
  - `burst_len`=0 means free-run.
  - PAUSE keeps the burst count. `stop` clears it without asserting `done`.
- Not defined: the ports are absent and RUN is always free-running.

## Structure
- Package `tick_gen_pkg`: state enum typedef (IDLE, RUN, PAUSE) and the `DEFAULT_DIV` constant.
- Sub-module `tick_prescaler` holds `pre`, `div_q`, `div_sh` and the wrap compare. Its inputs are `clr`, `hold`, `load`, `div_in`; its output is `wrap`.
- The FSM, `en` register and burst logic stay in the top module.

## Test plan
- Reset, then `div_in`=4 with `load_div`, then `start` → `en` pulses at cycles 4, 8, 12, … after start. A connected up-counter reads 10 after 40 cycles.
- `div_in`=0, start → `en` high every cycle. `stop` → `en`=0 on the next edge and `running`=0.
- Run with `div`=8, pause at `pre`=5 for 20 cycles, then `start` → next `en` exactly 3 cycles later.
- In IDLE, 3 `step` pulses 2 cycles apart → 3 single-cycle `en` pulses, each 1 cycle after its step; state stays IDLE.
- `load_div` of 3 during RUN with `div`=6 → current period stays 6, then the period becomes 3. `start`+`stop` on the same edge → remains IDLE.
- With macro, `burst_len`=5, `div`=2 → exactly 5 `en` pulses, `done` on the 5th, state back in IDLE. `rst` asserted mid-burst → all outputs 0.

Source files
------------

// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the enable-tick generator.
package tick_gen_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int DEFAULT_DIV = 10;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler for tick_gen: counts clocks up to the divisor and flags the wrap edge.
// Divisor writes made while counting are staged in a shadow and take effect at the next wrap.
module tick_prescaler
    import tick_gen_pkg::*;
#(
    parameter int DIV_W   = 8,
    parameter int RST_DIV = DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic             load,
    input  logic [DIV_W-1:0] div_in,
    output logic             wrap
);

    logic [DIV_W-1:0] pre;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_sh;
    logic [DIV_W-1:0] div_new;
    logic             active;

    assign div_new = (div_in == '0) ? DIV_W'(1) : div_in;
    assign active  = !clr && !hold;
    // >= keeps the period bounded if the divisor shrinks while pre is frozen
    assign wrap    = (pre >= div_q - DIV_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre    <= '0;
            div_q  <= DIV_W'(RST_DIV);
            div_sh <= DIV_W'(RST_DIV);
        end else begin
            if (clr) begin
                pre <= '0;
            end else if (active) begin
                pre <= wrap ? '0 : pre + DIV_W'(1);
            end

            if (active) begin
                if (load) begin
                    div_sh <= div_new;
                end
                if (wrap) begin
                    div_q <= load ? div_new : div_sh;
                end
            end else if (load) begin
                div_q  <= div_new;
                div_sh <= div_new;
            end
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Enable-tick generator feeding the up-counter: one-cycle en every div clocks under start/pause/stop/step control.
// Optional burst mode (fixed number of ticks per run, done pulse) is built when TICK_GEN_BURST_EN is defined.
//
// state | meaning
// IDLE  | prescaler cleared, step emits a single en
// RUN   | prescaler counting, en on each wrap
// PAUSE | prescaler frozen, start resumes, step emits a single en
module tick_gen #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = tick_gen_pkg::DEFAULT_DIV
`ifdef TICK_GEN_BURST_EN
    ,
    parameter int BURST_W     = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    input  logic             step,
    input  logic             load_div,
    input  logic [DIV_W-1:0] div_in,
    output logic             en,
    output logic             running,
    output logic             paused
`ifdef TICK_GEN_BURST_EN
    ,
    input  logic [BURST_W-1:0] burst_len,
    output logic               done
`endif
);

    import tick_gen_pkg::*;

    state_t state;
    logic   wrap;
    logic   clr;
    logic   hold;

`ifdef TICK_GEN_BURST_EN
    logic [BURST_W-1:0] bcnt;
`endif

    assign clr     = stop || (state == IDLE);
    assign hold    = (state != RUN) || (pause && !start);
    assign running = (state == RUN);
    assign paused  = (state == PAUSE);

    tick_prescaler #(
        .DIV_W   (DIV_W),
        .RST_DIV (DEFAULT_DIV)
    ) u_pre (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .hold   (hold),
        .load   (load_div),
        .div_in (div_in),
        .wrap   (wrap)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            en    <= 1'b0;
`ifdef TICK_GEN_BURST_EN
            bcnt  <= '0;
            done  <= 1'b0;
`endif
        end else begin
            en <= 1'b0;
`ifdef TICK_GEN_BURST_EN
            done <= 1'b0;
`endif
            if (stop) begin
                state <= IDLE;
`ifdef TICK_GEN_BURST_EN
                bcnt  <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state <= RUN;
`ifdef TICK_GEN_BURST_EN
                            bcnt  <= burst_len;
`endif
                        end else if (step) begin
                            en <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (pause && !start) begin
                            state <= PAUSE;
                        end else if (wrap) begin
                            en <= 1'b1;
`ifdef TICK_GEN_BURST_EN
                            // zero count means free-run; never decremented
                            if (bcnt != '0) begin
                                bcnt <= bcnt - BURST_W'(1);
                                if (bcnt == BURST_W'(1)) begin
                                    state <= IDLE;
                                    done  <= 1'b1;
                                end
                            end
`endif
                        end
                    end
                    PAUSE: begin
                        if (start) begin
                            state <= RUN;
                        end else if (step) begin
                            en <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_gen.sv
// Self-checking bench for tick_gen: cycle model based on remaining-cycles-to-tick plus directed literal checks.
// Burst scenarios are compiled in when TICK_GEN_BURST_EN is defined.
module tb_tick_gen;

    localparam int DIV_W = 8;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             start    = 1'b0;
    logic             pause    = 1'b0;
    logic             stop     = 1'b0;
    logic             step     = 1'b0;
    logic             load_div = 1'b0;
    logic [DIV_W-1:0] div_in   = '0;
    logic             en;
    logic             running;
    logic             paused;
`ifdef TICK_GEN_BURST_EN
    logic [3:0]       burst_len = '0;
    logic             done;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tick_gen #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .pause     (pause),
        .stop      (stop),
        .step      (step),
        .load_div  (load_div),
        .div_in    (div_in),
        .en        (en),
        .running   (running),
        .paused    (paused)
`ifdef TICK_GEN_BURST_EN
        ,
        .burst_len (burst_len),
        .done      (done)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: mode 0/1/2 = idle/run/pause, m_left = clock edges still to go before the next tick
    int m_mode  = 0;
    int m_left  = 0;
    int m_div   = 10;
    int m_pend  = -1;
    int m_bleft = 0;
    bit m_en    = 1'b0;
    bit m_done  = 1'b0;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_left = 0; m_div = 10; m_pend = -1; m_bleft = 0;
            m_en = 1'b0; m_done = 1'b0;
        end else begin
            bit counting;
            counting = (m_mode == 1) && !stop && !(pause && !start);
            m_en   = 1'b0;
            m_done = 1'b0;
            if (load_div) begin
                if (counting) m_pend = eff(int'(div_in));
                else begin
                    m_div  = eff(int'(div_in));
                    m_pend = -1;
                end
            end
            if (stop) begin
                m_mode  = 0;
                m_bleft = 0;
            end else if (m_mode == 0) begin
                if (start) begin
                    m_mode = 1;
                    m_left = m_div;
`ifdef TICK_GEN_BURST_EN
                    m_bleft = int'(burst_len);
`else
                    m_bleft = 0;
`endif
                end else if (step) m_en = 1'b1;
            end else if (m_mode == 1) begin
                if (!counting) m_mode = 2;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_en = 1'b1;
                        if (m_pend >= 0) begin
                            m_div  = m_pend;
                            m_pend = -1;
                        end
                        m_left = m_div;
                        if (m_bleft > 0) begin
                            m_bleft--;
                            if (m_bleft == 0) begin
                                m_mode = 0;
                                m_done = 1'b1;
                            end
                        end
                    end
                end
            end else begin
                if (start) m_mode = 1;
                else if (step) m_en = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        check("en", int'(en), int'(m_en));
        check("running", int'(running), (m_mode == 1) ? 1 : 0);
        check("paused", int'(paused), (m_mode == 2) ? 1 : 0);
`ifdef TICK_GEN_BURST_EN
        check("done", int'(done), int'(m_done));
`endif
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input int v);
        load_div = 1'b1;
        div_in   = DIV_W'(v);
        tick(1);
        load_div = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    // index (in cycles after the sampling edge) of the first en, -1 if none within the bound
    task automatic first_en(input int bound, output int k);
        k = -1;
        for (int i = 1; i <= bound; i++) begin
            tick(1);
            if (en) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        logic [3:0] ucnt;
        int k;
        int sum;
        int pos[4];
        int np;

        tick(3);
        rst = 1'b0;
        tick(1);
        check("rst_en", int'(en), 0);
        check("rst_running", int'(running), 0);
        check("rst_paused", int'(paused), 0);

        // div 4: en at 4, 8, ... ; external 4-bit counter sees 10 ticks in 40 cycles
        load(4);
        do_start();
        ucnt = '0;
        k = -1;
        for (int i = 1; i <= 40; i++) begin
            tick(1);
            if (en) begin
                ucnt = ucnt + 4'd1;
                if (k < 0) k = i;
            end
        end
        check("div4_first_en", k, 4);
        check("div4_count40", int'(ucnt), 10);
        do_stop();

        // div 0 behaves as 1: en every cycle, stop clears it next edge
        load(0);
        do_start();
        sum = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            sum += int'(en);
        end
        check("div1_every_cycle", sum, 5);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("div1_stop_en", int'(en), 0);
        check("div1_stop_running", int'(running), 0);

        // div 8, freeze at pre=5 for 20 cycles, resume: en 3 cycles later
        load(8);
        do_start();
        tick(5);
        pause = 1'b1;
        tick(1);
        pause = 1'b0;
        check("pause_flag", int'(paused), 1);
        tick(20);
        check("pause_held", int'(paused), 1);
        do_start();
        first_en(20, k);
        check("resume_latency", k, 3);
        do_stop();

        // three steps in IDLE, each giving one single-cycle en
        for (int s = 0; s < 3; s++) begin
            step = 1'b1;
            tick(1);
            step = 1'b0;
            check("step_en", int'(en), 1);
            check("step_idle", int'(running), 0);
            tick(1);
            check("step_en_low", int'(en), 0);
        end

        // shadow divisor: 6 -> 3 at the wrap, then 5 loaded on a wrap edge
        load(6);
        do_start();
        np = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (en && np < 4) begin
                pos[np] = i;
                np++;
            end
            load_div = (i == 1) || (i == 11);
            div_in   = (i == 11) ? DIV_W'(5) : DIV_W'(3);
        end
        load_div = 1'b0;
        check("shadow_n", np, 4);
        check("shadow_p0", pos[0], 6);
        check("shadow_p1", pos[1], 9);
        check("shadow_p2", pos[2], 12);
        check("shadow_p3", pos[3], 17);
        do_stop();
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        check("start_stop_idle", int'(running), 0);
        tick(1);
        check("start_stop_en", int'(en), 0);

        // async reset mid-period restores the default divisor
        load(4);
        do_start();
        tick(2);
        #2 rst = 1'b1;
        #1;
        check("arst_en", int'(en), 0);
        check("arst_running", int'(running), 0);
        check("arst_paused", int'(paused), 0);
        tick(1);
        rst = 1'b0;
        tick(4);
        do_start();
        first_en(30, k);
        check("arst_default_div", k, 10);
        do_stop();

`ifdef TICK_GEN_BURST_EN
        // burst of 5 ticks at div 2, done with the last one
        load(2);
        burst_len = 4'd5;
        do_start();
        sum = 0;
        k = -1;
        np = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            sum += int'(en);
            if (done) begin
                np++;
                k = i;
            end
        end
        check("burst_ticks", sum, 5);
        check("burst_done_n", np, 1);
        check("burst_done_pos", k, 10);
        check("burst_idle", int'(running), 0);
        do_start();
        tick(3);
        #2 rst = 1'b1;
        #1;
        check("burst_rst_en", int'(en), 0);
        check("burst_rst_done", int'(done), 0);
        check("burst_rst_running", int'(running), 0);
        tick(1);
        rst = 1'b0;
        tick(2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
